// File: rtl/timer_pkg.sv
// Shared BCD constants and preset validation for the seconds/minutes/hours timer stages.
package timer_pkg;

  localparam int              BCD_W        = 4;
  localparam logic [BCD_W-1:0] SEC_TENS_MAX = 4'd5;
  localparam logic [BCD_W-1:0] UNITS_MAX    = 4'd9;

  // A two-digit BCD value is loadable only if both digits sit inside their stage's range.
  function automatic logic bcd_valid(input logic [BCD_W-1:0] tens,
                                     input logic [BCD_W-1:0] units,
                                     input logic [BCD_W-1:0] tens_max);
    return (tens <= tens_max) && (units <= UNITS_MAX);
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Divides clk down to a one-cycle tick_int every CLK_DIV running cycles.
// half_int marks the half-period point only when SEC_BLINK_EN is defined; otherwise it is tied low.
module tick_prescaler #(
  parameter int CLK_DIV = 100_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  input  logic clr,
  output logic tick_int,
  output logic half_int
);

  localparam int DIV_W = $clog2(CLK_DIV);

  logic [DIV_W-1:0] div_q;
  logic [DIV_W-1:0] div_d;
  logic             at_top;

  assign at_top   = (div_q == DIV_W'(CLK_DIV - 1));
  assign tick_int = at_top && run;

`ifdef SEC_BLINK_EN
  assign half_int = (div_q == DIV_W'(CLK_DIV / 2 - 1)) && run;
`else
  assign half_int = 1'b0;
`endif

  // NOTE: every variable driven in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    div_d = div_q;
    if (clr)
      div_d = '0;
    else if (run)
      div_d = at_top ? '0 : div_q + 1'b1;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples the pre-edge values.
  always_ff @(posedge clk) begin
    if (rst)
      div_q <= '0;
    else
      div_q <= div_d;
  end

endmodule

// File: rtl/sec_tick_counter.sv
// Seconds stage of the timer chain: 1 Hz tick, BCD seconds 00..59, carry pulse and checked preset.
// Optional colon blink output is built only when SEC_BLINK_EN is defined.
module sec_tick_counter
  import timer_pkg::*;
#(
  parameter int CLK_DIV = 100_000_000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic             set_sec,
  input  logic [BCD_W-1:0] set_num1,
  input  logic [BCD_W-1:0] set_num2,
  output logic [BCD_W-1:0] out_q1,
  output logic [BCD_W-1:0] out_q2,
  output logic             out_co,
  output logic             tick,
  output logic             set_err,
  output logic             blink
);

  logic             tick_int;
  logic             half_int;
  logic             preset_ok;
  logic             load;
  logic             at_59;
  logic [BCD_W-1:0] tens_q, tens_d;
  logic [BCD_W-1:0] units_q, units_d;
  logic             tick_q, co_q, err_q;

  assign preset_ok = bcd_valid(set_num1, set_num2, SEC_TENS_MAX);
  assign load      = set_sec && preset_ok;
  assign at_59     = (tens_q == SEC_TENS_MAX) && (units_q == UNITS_MAX);

  tick_prescaler #(.CLK_DIV(CLK_DIV)) u_prescaler (
    .clk      (clk),
    .rst      (rst),
    .run      (run),
    .clr      (load),
    .tick_int (tick_int),
    .half_int (half_int)
  );

  // A valid preset wins over a due tick; an invalid one leaves counting untouched.
  always_comb begin
    tens_d  = tens_q;
    units_d = units_q;
    if (load) begin
      tens_d  = set_num1;
      units_d = set_num2;
    end else if (tick_int) begin
      if (units_q == UNITS_MAX) begin
        units_d = '0;
        tens_d  = (tens_q == SEC_TENS_MAX) ? '0 : tens_q + 1'b1;
      end else begin
        units_d = units_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tens_q  <= '0;
      units_q <= '0;
      tick_q  <= 1'b0;
      co_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      tens_q  <= tens_d;
      units_q <= units_d;
      tick_q  <= tick_int && !load;
      co_q    <= tick_int && !load && at_59;
      err_q   <= set_sec && !preset_ok;
    end
  end

`ifdef SEC_BLINK_EN
  logic blink_q, blink_d;

  always_comb begin
    blink_d = blink_q;
    if (load)
      blink_d = 1'b1;
    else if (tick_int || half_int)
      blink_d = ~blink_q;
  end

  always_ff @(posedge clk) begin
    if (rst)
      blink_q <= 1'b0;
    else
      blink_q <= blink_d;
  end

  assign blink = blink_q;
`else
  logic unused_half;
  assign unused_half = half_int;
  assign blink       = 1'b0;
`endif

  assign out_q1  = tens_q;
  assign out_q2  = units_q;
  assign out_co  = co_q;
  assign tick    = tick_q;
  assign set_err = err_q;

endmodule

// File: tb/tb_sec_tick_counter.sv
// Scoreboard bench for sec_tick_counter with CLK_DIV=4: every tick/carry/error pulse is matched
// against a queued expectation stamped with the clock edge on which it must appear.
module tb_sec_tick_counter;

  localparam int CLK_DIV = 4;

  typedef struct {
    int         cyc;
    logic [3:0] q1;
    logic [3:0] q2;
    logic       co;
    logic       err;
    logic       tk;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst, run, set_sec;
  logic [3:0] set_num1, set_num2;
  logic [3:0] out_q1, out_q2;
  logic       out_co, tick, set_err, blink;

  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  bit   blink_aligned = 1'b0;
  exp_t exp_q[$];

  sec_tick_counter #(.CLK_DIV(CLK_DIV)) dut (
    .clk      (clk),
    .rst      (rst),
    .run      (run),
    .set_sec  (set_sec),
    .set_num1 (set_num1),
    .set_num2 (set_num2),
    .out_q1   (out_q1),
    .out_q2   (out_q2),
    .out_co   (out_co),
    .tick     (tick),
    .set_err  (set_err),
    .blink    (blink)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic push(input int c, input logic [3:0] q1, input logic [3:0] q2,
                      input logic co, input logic err, input logic tk);
    exp_t e;
    e.cyc = c; e.q1 = q1; e.q2 = q2; e.co = co; e.err = err; e.tk = tk;
    exp_q.push_back(e);
  endtask

  task automatic drive(input logic r, input logic rn, input logic s,
                       input logic [3:0] n1, input logic [3:0] n2);
    rst = r; run = rn; set_sec = s; set_num1 = n1; set_num2 = n2;
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_q1"},    32'(out_q1),  32'd0);
    check({tag, "_q2"},    32'(out_q2),  32'd0);
    check({tag, "_co"},    32'(out_co),  32'd0);
    check({tag, "_tick"},  32'(tick),    32'd0);
    check({tag, "_err"},   32'(set_err), 32'd0);
    check({tag, "_blink"}, 32'(blink),   32'd0);
  endtask

  // Monitor: any pulse on tick/out_co/set_err is an output event and must match the queue head.
  always @(negedge clk) begin
    if (tick === 1'b1 || out_co === 1'b1 || set_err === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_event", {tick, out_co, set_err}, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("evt_cycle", 32'(cyc),     32'(e.cyc));
        check("evt_q1",    32'(out_q1),  32'(e.q1));
        check("evt_q2",    32'(out_q2),  32'(e.q2));
        check("evt_co",    32'(out_co),  32'(e.co));
        check("evt_err",   32'(set_err), 32'(e.err));
        check("evt_tick",  32'(tick),    32'(e.tk));
`ifdef SEC_BLINK_EN
        if (blink_aligned && e.tk) check("evt_blink_hi", 32'(blink), 32'd1);
`else
        check("evt_blink_off", 32'(blink), 32'd0);
`endif
      end
    end
  end

  initial begin
    // Reset held 3 cycles with run and a valid preset requested: reset must win.
    drive(1'b1, 1'b1, 1'b1, 4'd5, 4'd5);
    step(3);
    check_reset_state("rst_init");

    // Free run from 00: first tick 4 edges after release.
    drive(1'b0, 1'b1, 1'b0, 4'd0, 4'd0);
    push(7,  4'd0, 4'd1, 1'b0, 1'b0, 1'b1);
    push(11, 4'd0, 4'd2, 1'b0, 1'b0, 1'b1);
    push(15, 4'd0, 4'd3, 1'b0, 1'b0, 1'b1);
    step(14);

    // Preset 58, then 59 and the 59->00 roll with carry.
    drive(1'b0, 1'b1, 1'b1, 4'd5, 4'd8);
    step(1);
    drive(1'b0, 1'b1, 1'b0, 4'd0, 4'd0);
    blink_aligned = 1'b1;
    push(22, 4'd5, 4'd9, 1'b0, 1'b0, 1'b1);
    push(26, 4'd0, 4'd0, 1'b1, 1'b0, 1'b1);
    step(8);

    // Invalid presets: bad tens, then bad units; counting carries on.
    drive(1'b0, 1'b1, 1'b1, 4'd6, 4'd3);
    push(27, 4'd0, 4'd0, 1'b0, 1'b1, 1'b0);
    step(1);
    drive(1'b0, 1'b1, 1'b1, 4'd2, 4'hA);
    push(28, 4'd0, 4'd0, 1'b0, 1'b1, 1'b0);
    step(1);
    drive(1'b0, 1'b1, 1'b0, 4'd0, 4'd0);
    push(30, 4'd0, 4'd1, 1'b0, 1'b0, 1'b1);
    step(5);

    // Preset 59 exactly when a tick is due: no tick/carry, full second until the roll.
    drive(1'b0, 1'b1, 1'b1, 4'd5, 4'd9);
    step(1);
    drive(1'b0, 1'b1, 1'b0, 4'd0, 4'd0);
    push(38, 4'd0, 4'd0, 1'b1, 1'b0, 1'b1);
    step(4);

    // Preset 59 then 00: a preset never produces a carry.
    drive(1'b0, 1'b1, 1'b1, 4'd5, 4'd9);
    step(1);
    drive(1'b0, 1'b1, 1'b1, 4'd0, 4'd0);
    step(1);
    drive(1'b0, 1'b1, 1'b0, 4'd0, 4'd0);
    push(44, 4'd0, 4'd1, 1'b0, 1'b0, 1'b1);
    step(6);

    // Pause at div_cnt=2 for 10 cycles; resume finishes the partial second.
    drive(1'b0, 1'b0, 1'b0, 4'd0, 4'd0);
    step(10);
    drive(1'b0, 1'b1, 1'b0, 4'd0, 4'd0);
    push(58, 4'd0, 4'd2, 1'b0, 1'b0, 1'b1);
    step(5);

    // Reset on the edge where a tick is due.
    drive(1'b1, 1'b1, 1'b0, 4'd0, 4'd0);
    blink_aligned = 1'b0;
    step(1);
    check_reset_state("rst_mid");
    drive(1'b0, 1'b1, 1'b0, 4'd0, 4'd0);
    push(66, 4'd0, 4'd1, 1'b0, 1'b0, 1'b1);
    step(4);

    // Valid preset held 6 cycles suspends counting; next tick a full second after release.
    drive(1'b0, 1'b1, 1'b1, 4'd3, 4'd7);
    blink_aligned = 1'b1;
    push(76, 4'd3, 4'd8, 1'b0, 1'b0, 1'b1);
    step(6);
    drive(1'b0, 1'b1, 1'b0, 4'd0, 4'd0);
    step(8);

    check("events_outstanding", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
